// File: rtl/sipo_buffered.sv
// Serial-in parallel-out assembler with a one-word output slot and one held word in assembly.
// Optional out_parity port (XOR of out_data) is enabled by defining SIPO_PARITY_EN.
module sipo_buffered #(
    parameter int SIZE      = 8,
    parameter int LANES     = 1,
    parameter int SHIFT_DIR = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LANES-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [SIZE-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef SIPO_PARITY_EN
    output logic             out_parity,
`endif
    output logic             overrun
);

    localparam int BEATS = SIZE / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    // Handshake: a beat moves when in_valid && in_ready; a word moves when
    // out_valid && out_ready. Neither ready depends on its own valid.
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] asm_reg;
    logic            held;
    logic [SIZE-1:0] word;
    logic [SIZE-1:0] load_val;
    logic            accept, consume, slot_free, last_beat;
    logic            load_direct, load_held, load_out;

    assign in_ready  = !held;
    assign busy      = (cnt != '0);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;
    assign last_beat = accept && (cnt == LAST_BEAT);

    // Assembly register with the current beat merged into its lane slot
    always_comb begin
        word = asm_reg;
        if (SHIFT_DIR == 0)
            word[int'(cnt) * LANES +: LANES] = in_data;
        else
            word[SIZE - (int'(cnt) + 1) * LANES +: LANES] = in_data;
    end

    always_comb begin
        load_direct = !flush && last_beat && slot_free;
        load_held   = !flush && held && out_ready;
        load_out    = load_direct || load_held;
        load_val    = held ? asm_reg : word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            asm_reg <= '0;
            held    <= 1'b0;
        end else if (flush) begin
            cnt     <= '0;
            asm_reg <= '0;
            held    <= 1'b0;
        end else if (load_held) begin
            asm_reg <= '0;
            held    <= 1'b0;
        end else if (last_beat) begin
            cnt <= '0;
            if (slot_free) begin
                asm_reg <= '0;
            end else begin
                // Slot is occupied: park the complete word and stall input
                asm_reg <= word;
                held    <= 1'b1;
            end
        end else if (accept) begin
            asm_reg <= word;
            cnt     <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_data  <= load_val;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_parity <= 1'b0;
        else if (load_out)
            out_parity <= ^load_val;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun <= 1'b0;
        else if (in_valid && !in_ready)
            overrun <= 1'b1;
    end

endmodule

// File: tb/tb_sipo_buffered.sv
// Bench for sipo_buffered: two 8x1 instances (LSB-first and MSB-first) against a word-level model,
// plus a 16x4 instance for directed multi-lane streaming. Checks out_parity when SIPO_PARITY_EN is set.
module tb_sipo_buffered;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       in_data, in_valid, flush, out_ready;
  logic       in_ready0, out_valid0, busy0, overrun0;
  logic       in_ready1, out_valid1, busy1, overrun1;
  logic [7:0] out_data0, out_data1;

  logic [3:0]  in_data2;
  logic        in_valid2, flush2, out_ready2;
  logic        in_ready2, out_valid2, busy2, overrun2;
  logic [15:0] out_data2;

`ifdef SIPO_PARITY_EN
  logic out_parity0, out_parity1, out_parity2;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model: beats of the 8x1 stream and the word-level slot/held state
  int         m_beats[$];
  logic       m_slot_v, m_held_v, m_ovr;
  logic [7:0] m_slot0, m_slot1, m_held0, m_held1;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  // Clock / reset block
  always #5 clk = ~clk;

  sipo_buffered #(.SIZE(8), .LANES(1), .SHIFT_DIR(0)) u0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .flush(flush), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .busy(busy0),
`ifdef SIPO_PARITY_EN
    .out_parity(out_parity0),
`endif
    .overrun(overrun0));

  sipo_buffered #(.SIZE(8), .LANES(1), .SHIFT_DIR(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .flush(flush), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1),
`ifdef SIPO_PARITY_EN
    .out_parity(out_parity1),
`endif
    .overrun(overrun1));

  sipo_buffered #(.SIZE(16), .LANES(4), .SHIFT_DIR(0)) u2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .flush(flush2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .busy(busy2),
`ifdef SIPO_PARITY_EN
    .out_parity(out_parity2),
`endif
    .overrun(overrun2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    exp_q0.delete();
    exp_q1.delete();
    m_slot_v = 1'b0;
    m_held_v = 1'b0;
    m_ovr    = 1'b0;
    m_slot0  = '0;
    m_slot1  = '0;
    m_held0  = '0;
    m_held1  = '0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic fl, input logic ordy);
    logic       ready, consume, free;
    logic [7:0] w0, w1;
    ready   = !m_held_v;
    consume = m_slot_v && ordy;
    free    = !m_slot_v || ordy;
    if (v && !ready) m_ovr = 1'b1;
    if (consume) m_slot_v = 1'b0;
    if (fl) begin
      m_beats.delete();
      m_held_v = 1'b0;
    end else if (m_held_v && consume) begin
      m_slot0 = m_held0; m_slot1 = m_held1;
      m_slot_v = 1'b1; m_held_v = 1'b0;
      exp_q0.push_back(m_slot0); exp_q1.push_back(m_slot1);
    end else if (v && ready) begin
      m_beats.push_back(int'(b));
      if (m_beats.size() == 8) begin
        w0 = '0; w1 = '0;
        for (int k = 0; k < 8; k++) begin
          w0 = w0 | (8'(m_beats[k]) << k);
          w1 = w1 | (8'(m_beats[k]) << (7 - k));
        end
        m_beats.delete();
        if (free) begin
          m_slot0 = w0; m_slot1 = w1; m_slot_v = 1'b1;
          exp_q0.push_back(w0); exp_q1.push_back(w1);
        end else begin
          m_held0 = w0; m_held1 = w1; m_held_v = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid0", 32'(out_valid0), 32'(m_slot_v));
    chk("out_valid1", 32'(out_valid1), 32'(m_slot_v));
    chk("in_ready0", 32'(in_ready0), 32'(!m_held_v));
    chk("in_ready1", 32'(in_ready1), 32'(!m_held_v));
    chk("busy0", 32'(busy0), 32'(m_beats.size() != 0));
    chk("busy1", 32'(busy1), 32'(m_beats.size() != 0));
    chk("overrun0", 32'(overrun0), 32'(m_ovr));
    chk("overrun1", 32'(overrun1), 32'(m_ovr));
    if (m_slot_v) begin
      chk("out_data0", 32'(out_data0), 32'(m_slot0));
      chk("out_data1", 32'(out_data1), 32'(m_slot1));
`ifdef SIPO_PARITY_EN
      chk("out_parity0", 32'(out_parity0), 32'(^m_slot0));
      chk("out_parity1", 32'(out_parity1), 32'(^m_slot1));
`endif
    end
  endtask

  // Driver: inputs change at the falling edge, model steps at the rising edge
  task automatic drive(input logic v, input logic b, input logic fl, input logic ordy);
    logic [7:0] e0, e1;
    in_valid = v; in_data = b; flush = fl; out_ready = ordy;
    if (m_slot_v && ordy) begin
      if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
        chk("scoreboard_empty", 32'(exp_q0.size()), 32'd1);
      end else begin
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        chk("consumed0", 32'(out_data0), 32'(e0));
        chk("consumed1", 32'(out_data1), 32'(e1));
      end
    end
    @(posedge clk);
    model_step(v, b, fl, ordy);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_word(input logic [7:0] w, input logic ordy);
    for (int k = 0; k < 8; k++) drive(1'b1, w[k], 1'b0, ordy);
  endtask

  task automatic drive2(input logic [3:0] d, input logic v, input logic ordy);
    in_data2 = d; in_valid2 = v; out_ready2 = ordy;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] nib;
    in_data = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b0;
    model_reset();

    // Reset values, observed before any clock edge
    #3;
    chk("rst_out_data0", 32'(out_data0), 32'd0);
    chk("rst_out_valid0", 32'(out_valid0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_overrun0", 32'(overrun0), 32'd0);
    chk("rst_in_ready0", 32'(in_ready0), 32'd1);
    chk("rst_in_ready2", 32'(in_ready2), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // LSB-first / MSB-first single-bit stream 1,0,1,1,0,0,1,0
    send_word(8'h4D, 1'b0);
    chk("w4d_data0", 32'(out_data0), 32'h4D);
    chk("w4d_data1", 32'(out_data1), 32'hB2);
    chk("w4d_valid0", 32'(out_valid0), 32'd1);
    chk("w4d_busy0", 32'(busy0), 32'd0);
`ifdef SIPO_PARITY_EN
    chk("w4d_parity0", 32'(out_parity0), 32'd0);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Two words with no consumer: first holds, second parks, extra beat overruns
    send_word(8'h4D, 1'b0);
    send_word(8'h96, 1'b0);
    chk("hold_data0", 32'(out_data0), 32'h4D);
    chk("hold_in_ready0", 32'(in_ready0), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_overrun0", 32'(overrun0), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_data0", 32'(out_data0), 32'h96);
    chk("release_valid0", 32'(out_valid0), 32'd1);
    chk("release_in_ready0", 32'(in_ready0), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Partial word then flush: no residue in the next word
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("flush_busy0", 32'(busy0), 32'd0);
    send_word(8'hFF, 1'b0);
    chk("flush_data0", 32'(out_data0), 32'hFF);
    chk("flush_data1", 32'(out_data1), 32'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    send_word(8'h4C, 1'b0);
    chk("w4c_data0", 32'(out_data0), 32'h4C);
`ifdef SIPO_PARITY_EN
    chk("w4c_parity0", 32'(out_parity0), 32'd1);
`endif

    // 16x4: two back-to-back words, consumer always ready, in_ready never drops
    nib = 16'h4321;
    for (int k = 0; k < 4; k++) begin
      drive2(nib[k*4 +: 4], 1'b1, 1'b1);
      chk("lanes_in_ready2", 32'(in_ready2), 32'd1);
    end
    chk("lanes_word1", 32'(out_data2), 32'h4321);
    chk("lanes_valid1", 32'(out_valid2), 32'd1);
    nib = 16'hDCBA;
    for (int k = 0; k < 4; k++) begin
      drive2(nib[k*4 +: 4], 1'b1, 1'b1);
      chk("lanes_in_ready2", 32'(in_ready2), 32'd1);
    end
    chk("lanes_word2", 32'(out_data2), 32'hDCBA);
    chk("lanes_valid2", 32'(out_valid2), 32'd1);
    drive2(4'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-word with a word still in the slot
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_data0", 32'(out_data0), 32'd0);
    chk("arst_out_valid0", 32'(out_valid0), 32'd0);
    chk("arst_busy0", 32'(busy0), 32'd0);
    chk("arst_overrun0", 32'(overrun0), 32'd0);
    chk("arst_in_ready0", 32'(in_ready0), 32'd1);
`ifdef SIPO_PARITY_EN
    chk("arst_parity0", 32'(out_parity0), 32'd0);
`endif
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Beat 0 lands in bit 0 right after release
    w = 8'(($urandom_range(0, 255)) | 1);
    send_word(w, 1'b0);
    chk("post_rst_word0", 32'(out_data0), 32'(w));
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
